// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction (I) and data (D) requester, with a
// one-outstanding-transaction FSM and a hang timeout. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        imem_req_ready,
  input  logic [31:0] imem_req_addr,
  output logic [31:0] imem_resp_data,
  output logic        imem_resp_valid,
  output logic        imem_resp_err,

  input  logic        dmem_req_ready,
  input  logic [31:0] dmem_req_addr,
  input  logic        dmem_req_write_enable,
  input  logic [31:0] dmem_req_write_data,
  input  logic [2:0]  dmem_req_data_width,
  output logic [31:0] dmem_resp_data,
  output logic        dmem_resp_valid,
  output logic        dmem_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [2:0]  mem_req_width,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam bit             TimeoutEn   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]     IWidth      = 3'b010;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e             state_q;
  logic               owner_d_q;  // 1: D owns the in-flight access, 0: I
  logic               mem_req_valid_q;
  logic [31:0]        mem_req_addr_q;
  logic               mem_req_we_q;
  logic [31:0]        mem_req_wdata_q;
  logic [2:0]         mem_req_width_q;
  logic [CNT_W-1:0]   cnt_q;

  logic any_req;
  logic grant_d;
  logic busy;
  logic done;
  logic timeout_hit;
  logic finish;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // On a tie, grant whichever port did not win last time.
  always_comb begin
    grant_d = dmem_req_ready & (~imem_req_ready | ~last_d_q);
  end
`else
  always_comb begin
    grant_d = dmem_req_ready;
  end
`endif

  always_comb begin
    any_req = imem_req_ready | dmem_req_ready;
    busy    = (state_q != StIdle);
    // A response counts in ISSUE only when it arrives together with the accept.
    done    = ((state_q == StWait) & mem_resp_valid) |
              ((state_q == StIssue) & mem_req_ready & mem_resp_valid);
    timeout_hit = TimeoutEn & busy & ~done & (cnt_q == TimeoutLast);
    finish      = done | timeout_hit;
  end

  always_comb begin
    imem_resp_valid = finish & ~owner_d_q;
    imem_resp_err   = timeout_hit & ~owner_d_q;
    imem_resp_data  = (done & ~owner_d_q) ? mem_resp_data : 32'h0;
    dmem_resp_valid = finish & owner_d_q;
    dmem_resp_err   = timeout_hit & owner_d_q;
    dmem_resp_data  = (done & owner_d_q) ? mem_resp_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      owner_d_q       <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= 32'h0;
      mem_req_we_q    <= 1'b0;
      mem_req_wdata_q <= 32'h0;
      mem_req_width_q <= 3'b000;
      cnt_q           <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q        <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_d_q       <= grant_d;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= grant_d ? dmem_req_addr : imem_req_addr;
            mem_req_we_q    <= grant_d & dmem_req_write_enable;
            mem_req_wdata_q <= grant_d ? dmem_req_write_data : 32'h0;
            mem_req_width_q <= grant_d ? dmem_req_data_width : IWidth;
            cnt_q           <= '0;
            state_q         <= StIssue;
`ifdef MEM_ARB_RR_EN
            last_d_q        <= grant_d;
`endif
          end
        end
        StIssue: begin
          if (finish) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= StIdle;
          end else if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= cnt_q + CNT_W'(1);
            state_q         <= StWait;
          end else begin
            cnt_q           <= cnt_q + CNT_W'(1);
          end
        end
        StWait: begin
          if (finish) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    mem_req_valid = mem_req_valid_q;
    mem_req_addr  = mem_req_addr_q;
    mem_req_we    = mem_req_we_q;
    mem_req_wdata = mem_req_wdata_q;
    mem_req_width = mem_req_width_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle, plus pinned
// literal expectations for the key scenarios (TIMEOUT fixed at 4).
module tb_mem_arbiter;

  localparam int unsigned To = 4;

  localparam int SelIv = 0, SelIerr = 1, SelIdata = 2, SelDv = 3, SelDerr = 4, SelDdata = 5;
  localparam int SelMv = 6, SelMaddr = 7, SelMwe = 8, SelMwidth = 9, SelMwdata = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic [31:0] imem_resp_data;
  logic        imem_resp_valid;
  logic        imem_resp_err;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_write_enable;
  logic [31:0] dmem_req_write_data;
  logic [2:0]  dmem_req_data_width;
  logic [31:0] dmem_resp_data;
  logic        dmem_resp_valid;
  logic        dmem_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [2:0]  mem_req_width;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  mem_arbiter #(
    .TIMEOUT(To),
    .CNT_W  (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .imem_req_ready       (imem_req_ready),
    .imem_req_addr        (imem_req_addr),
    .imem_resp_data       (imem_resp_data),
    .imem_resp_valid      (imem_resp_valid),
    .imem_resp_err        (imem_resp_err),
    .dmem_req_ready       (dmem_req_ready),
    .dmem_req_addr        (dmem_req_addr),
    .dmem_req_write_enable(dmem_req_write_enable),
    .dmem_req_write_data  (dmem_req_write_data),
    .dmem_req_data_width  (dmem_req_data_width),
    .dmem_resp_data       (dmem_resp_data),
    .dmem_resp_valid      (dmem_resp_valid),
    .dmem_resp_err        (dmem_resp_err),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_req_we           (mem_req_we),
    .mem_req_wdata        (mem_req_wdata),
    .mem_req_width        (mem_req_width),
    .mem_resp_valid       (mem_resp_valid),
    .mem_resp_data        (mem_resp_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned at;
    int          sel;
    logic [31:0] val;
    string       name;
  } lit_t;
  lit_t lits[$];

  // Transaction-level model: at most one access in flight, described by its owner and fields.
  bit          m_busy = 1'b0;
  bit          m_owner_d = 1'b1;
  bit          m_accepted = 1'b0;
  int unsigned m_age = 0;
  logic [31:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [2:0]  m_width = '0;
  bit          m_last_d = 1'b1;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      SelIv:     return {31'h0, imem_resp_valid};
      SelIerr:   return {31'h0, imem_resp_err};
      SelIdata:  return imem_resp_data;
      SelDv:     return {31'h0, dmem_resp_valid};
      SelDerr:   return {31'h0, dmem_resp_err};
      SelDdata:  return dmem_resp_data;
      SelMv:     return {31'h0, mem_req_valid};
      SelMaddr:  return mem_req_addr;
      SelMwe:    return {31'h0, mem_req_we};
      SelMwidth: return {29'h0, mem_req_width};
      default:   return mem_req_wdata;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit done, tout, pick_d;
    // Pinned literal expectations for this cycle.
    while (lits.size() > 0 && lits[0].at == cyc) begin
      chk(lits[0].name, probe(lits[0].sel), lits[0].val);
      void'(lits.pop_front());
    end
    // Model comparison.
    done = m_busy && mem_resp_valid && (m_accepted || mem_req_ready);
    tout = m_busy && !done && (m_age == To - 1);
    chk("m_imem_valid", {31'h0, imem_resp_valid}, {31'h0, (done || tout) && !m_owner_d});
    chk("m_imem_err",   {31'h0, imem_resp_err},   {31'h0, tout && !m_owner_d});
    chk("m_imem_data",  imem_resp_data, (done && !m_owner_d) ? mem_resp_data : 32'h0);
    chk("m_dmem_valid", {31'h0, dmem_resp_valid}, {31'h0, (done || tout) && m_owner_d});
    chk("m_dmem_err",   {31'h0, dmem_resp_err},   {31'h0, tout && m_owner_d});
    chk("m_dmem_data",  dmem_resp_data, (done && m_owner_d) ? mem_resp_data : 32'h0);
    chk("m_req_valid",  {31'h0, mem_req_valid},   {31'h0, m_busy && !m_accepted});
    if (m_busy && !m_accepted) begin
      chk("m_req_addr",  mem_req_addr, m_addr);
      chk("m_req_we",    {31'h0, mem_req_we}, {31'h0, m_we});
      chk("m_req_width", {29'h0, mem_req_width}, {29'h0, m_width});
      if (m_owner_d) chk("m_req_wdata", mem_req_wdata, m_wdata);
    end
    // Advance the model across the coming edge.
    if (reset) begin
      m_busy   = 1'b0;
      m_last_d = 1'b1;
    end else if (m_busy) begin
      if (done || tout) begin
        m_busy = 1'b0;
      end else begin
        if (mem_req_ready) m_accepted = 1'b1;
        m_age++;
      end
    end else if (imem_req_ready || dmem_req_ready) begin
`ifdef MEM_ARB_RR_EN
      pick_d = dmem_req_ready && (!imem_req_ready || !m_last_d);
`else
      pick_d = dmem_req_ready;
`endif
      m_busy     = 1'b1;
      m_accepted = 1'b0;
      m_age      = 0;
      m_owner_d  = pick_d;
      m_last_d   = pick_d;
      m_addr     = pick_d ? dmem_req_addr : imem_req_addr;
      m_we       = pick_d && dmem_req_write_enable;
      m_wdata    = dmem_req_write_data;
      m_width    = pick_d ? dmem_req_data_width : 3'b010;
    end
  end

  task automatic nxt(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input int sel, input logic [31:0] val, input string name);
    lit_t e;
    e.at = cyc; e.sel = sel; e.val = val; e.name = name;
    lits.push_back(e);
  endtask

  bit d_first;

  initial begin
    reset = 1'b1;
    imem_req_ready = 0; imem_req_addr = 0;
    dmem_req_ready = 0; dmem_req_addr = 0; dmem_req_write_enable = 0;
    dmem_req_write_data = 0; dmem_req_data_width = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    nxt(1);
    lit(SelMv, 0, "rst_req_valid"); lit(SelIv, 0, "rst_imem_valid"); lit(SelDv, 0, "rst_dmem_valid");
    lit(SelMaddr, 0, "rst_req_addr");
    nxt(2);
    reset = 1'b0;
    nxt(1);

    // I only, minimum latency.
    imem_req_ready = 1; imem_req_addr = 32'h100;
    nxt(1);
    lit(SelMv, 1, "i_req_valid"); lit(SelMaddr, 32'h100, "i_req_addr");
    lit(SelMwe, 0, "i_req_we"); lit(SelMwidth, 2, "i_req_width");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
    lit(SelIv, 1, "i_resp_valid"); lit(SelIdata, 32'hDEADBEEF, "i_resp_data");
    lit(SelIerr, 0, "i_resp_err"); lit(SelMv, 0, "i_req_dropped");
    nxt(1);
    imem_req_ready = 0; mem_resp_valid = 0;
    nxt(1);

    // Simultaneous I and D after an I grant: D goes first in either mode.
    dmem_req_ready = 1; dmem_req_addr = 32'h200; dmem_req_write_enable = 1;
    dmem_req_write_data = 32'h55; dmem_req_data_width = 3'b000;
    imem_req_ready = 1; imem_req_addr = 32'h300;
    nxt(1);
    lit(SelMaddr, 32'h200, "pair_d_addr"); lit(SelMwe, 1, "pair_d_we");
    lit(SelMwidth, 0, "pair_d_width"); lit(SelMwdata, 32'h55, "pair_d_wdata");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0;
    lit(SelDv, 1, "pair_d_resp"); lit(SelIv, 0, "pair_i_quiet");
    nxt(1);
    mem_resp_valid = 0; dmem_req_ready = 0;
    lit(SelMv, 0, "pair_idle_gap");
    nxt(1);
    lit(SelMv, 1, "pair_i_valid"); lit(SelMaddr, 32'h300, "pair_i_addr"); lit(SelMwe, 0, "pair_i_we");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h12345678;
    lit(SelIv, 1, "pair_i_resp"); lit(SelIdata, 32'h12345678, "pair_i_data");
    nxt(1);
    imem_req_ready = 0; mem_resp_valid = 0;
    nxt(1);

    // D load stalled 3 cycles, accepted and answered on the last-count cycle.
    dmem_req_ready = 1; dmem_req_addr = 32'h400; dmem_req_write_enable = 0;
    dmem_req_write_data = 0; dmem_req_data_width = 3'b010;
    nxt(1);
    for (int k = 0; k < 3; k++) begin
      lit(SelMv, 1, "stall_valid"); lit(SelMaddr, 32'h400, "stall_addr");
      nxt(1);
    end
    lit(SelMv, 1, "stall_valid_4th"); lit(SelMaddr, 32'h400, "stall_addr_4th");
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'hCAFEF00D;
    lit(SelDv, 1, "stall_resp"); lit(SelDerr, 0, "stall_err_wins");
    lit(SelDdata, 32'hCAFEF00D, "stall_data");
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 0; dmem_req_ready = 0;
    lit(SelMv, 0, "stall_done");
    nxt(1);

    // Simultaneous pair after a D grant: round-robin picks I, fixed priority picks D.
`ifdef MEM_ARB_RR_EN
    d_first = 1'b0;
`else
    d_first = 1'b1;
`endif
    dmem_req_ready = 1; dmem_req_addr = 32'h500; dmem_req_data_width = 3'b010;
    imem_req_ready = 1; imem_req_addr = 32'h600;
    nxt(1);
    lit(SelMaddr, d_first ? 32'h500 : 32'h600, "pair2_first_addr");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hAAAA0001;
    lit(d_first ? SelDv : SelIv, 1, "pair2_first_resp");
    lit(d_first ? SelIv : SelDv, 0, "pair2_other_quiet");
    nxt(1);
    mem_resp_valid = 0;
    if (d_first) dmem_req_ready = 0; else imem_req_ready = 0;
    nxt(1);
    lit(SelMaddr, d_first ? 32'h600 : 32'h500, "pair2_second_addr");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hAAAA0002;
    lit(d_first ? SelIv : SelDv, 1, "pair2_second_resp");
    nxt(1);
    mem_resp_valid = 0; dmem_req_ready = 0; imem_req_ready = 0;
    nxt(1);

    // Timeout: accepted but never answered.
    mem_resp_data = 32'h11111111;
    imem_req_ready = 1; imem_req_addr = 32'h700;
    nxt(1);
    lit(SelMv, 1, "to_valid_c1");
    nxt(1);
    lit(SelMv, 1, "to_valid_c2");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0;
    lit(SelMv, 0, "to_wait"); lit(SelIv, 0, "to_not_yet");
    nxt(1);
    lit(SelIv, 1, "to_resp_valid"); lit(SelIerr, 1, "to_resp_err"); lit(SelIdata, 0, "to_resp_data");
    nxt(1);
    imem_req_ready = 0;
    lit(SelMv, 0, "to_after"); lit(SelIv, 0, "to_after_quiet");
    nxt(1);
    mem_resp_valid = 1;
    lit(SelIv, 0, "to_stray_i"); lit(SelDv, 0, "to_stray_d");
    nxt(1);
    mem_resp_valid = 0;
    nxt(1);

    // Reset while waiting; the late response must be ignored.
    dmem_req_ready = 1; dmem_req_addr = 32'h800; dmem_req_write_enable = 1;
    dmem_req_write_data = 32'h99; dmem_req_data_width = 3'b001;
    nxt(1);
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; reset = 1;
    lit(SelDv, 0, "rstw_quiet");
    nxt(1);
    reset = 0; dmem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hBAD0BAD0;
    lit(SelMv, 0, "rstw_req_valid"); lit(SelDv, 0, "rstw_late_d");
    lit(SelDdata, 0, "rstw_late_data"); lit(SelIv, 0, "rstw_late_i");
    nxt(1);
    mem_resp_valid = 0;
    lit(SelMv, 0, "rstw_idle");
    nxt(1);

    // Completion in ISSUE, then an immediate follow-on D request.
    dmem_req_ready = 1; dmem_req_addr = 32'h900; dmem_req_write_enable = 0;
    dmem_req_data_width = 3'b010;
    nxt(1);
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h1;
    lit(SelDv, 1, "b2b_first_resp"); lit(SelDdata, 32'h1, "b2b_first_data");
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 0; dmem_req_addr = 32'h904;
    lit(SelMv, 0, "b2b_gap"); lit(SelDv, 0, "b2b_gap_quiet");
    nxt(1);
    lit(SelMv, 1, "b2b_second_valid"); lit(SelMaddr, 32'h904, "b2b_second_addr");
    mem_req_ready = 1;
    nxt(1);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h2;
    lit(SelDv, 1, "b2b_second_resp");
    nxt(1);
    dmem_req_ready = 0; mem_resp_valid = 0;
    nxt(3);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
